// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access stage.
// Holds the lane opcode encoding, the stage FSM state type, and small
// opcode classification helpers used by the stage datapath.
package mem_access_pkg;

  localparam logic [2:0] OP_CLEAR  = 3'd0;
  localparam logic [2:0] OP_PASS   = 3'd1;
  localparam logic [2:0] OP_RAM_LD = 3'd2;
  localparam logic [2:0] OP_RAM_ST = 3'd3;
  localparam logic [2:0] OP_SYS_LD = 3'd4;
  localparam logic [2:0] OP_SYS_ST = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_BUS  = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  // Lane needs a bus transaction (loads and stores on either bus target).
  function automatic logic op_is_mem(input logic [2:0] op);
    return (op >= OP_RAM_LD) && (op <= OP_SYS_ST);
  endfunction

  function automatic logic op_is_store(input logic [2:0] op);
    return (op == OP_RAM_ST) || (op == OP_SYS_ST);
  endfunction

  function automatic logic op_is_sys(input logic [2:0] op);
    return (op == OP_SYS_LD) || (op == OP_SYS_ST);
  endfunction

endpackage

// File: rtl/mem_lane_pick.sv
// Lowest-index priority encoder over the pending-lane mask.
// Ports:
//   pend : one bit per lane, 1 = lane still needs a bus transaction
//   idx  : index of the lowest set bit of pend (0 when none set)
//   any  : 1 when at least one bit of pend is set
module mem_lane_pick #(
  parameter int LANES = 2,
  parameter int IW    = 1
) (
  input  logic [LANES-1:0] pend,
  output logic [IW-1:0]    idx,
  output logic             any
);

  // Walk from the top lane downward so the lowest pending lane is the last writer.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      idx = pend[i] ? IW'(i) : idx;
      any = any | pend[i];
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory access stage: accepts a bundle of LANES operations, resolves
// CLEAR/PASS lanes immediately, then serialises the memory lanes onto a
// single request/ack bus (lowest lane first), aborting any transaction
// that waits TIMEOUT cycles, and finally presents the per-lane results.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              bundle handshake
//   in_op/in_data/in_addr          per-lane opcode, operand, address
//   proceed                        0 = treat every lane as CLEAR
//   out_valid/out_ready            result handshake
//   out_data/out_err               per-lane result, per-lane timeout flag
//   bus_req/we/sys/addr/wdata      bus request (sys: 0=RAM, 1=SYS)
//   bus_ack/bus_rdata              bus response
module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int LANES   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*3-1:0]    in_op,
  input  logic [LANES*DW-1:0]   in_data,
  input  logic [LANES*AW-1:0]   in_addr,
  input  logic                  proceed,
  output logic                  out_valid,
  output logic [LANES*DW-1:0]   out_data,
  output logic [LANES-1:0]      out_err,
  input  logic                  out_ready,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic                  bus_sys,
  output logic [AW-1:0]         bus_addr,
  output logic [DW-1:0]         bus_wdata,
  input  logic                  bus_ack,
  input  logic [DW-1:0]         bus_rdata
);

  localparam int         IW       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT - 1);

  mem_state_e                 state_r, state_nxt_s;
  logic [LANES-1:0][2:0]      cap_op_s;
  logic [LANES-1:0][2:0]      op_r;
  logic [LANES-1:0][DW-1:0]   data_r;
  logic [LANES-1:0][AW-1:0]   addr_r;
  logic [LANES-1:0][DW-1:0]   res_r;
  logic [LANES-1:0]           err_r;
  logic [LANES-1:0]           pend_r;
  logic [IW-1:0]              sel_r;
  logic [IW-1:0]              pick_idx_s;
  logic                       pick_any_s;
  logic [7:0]                 wait_r;
  logic                       wait_hit_s;
  logic                       in_ready_r, out_valid_r, bus_req_r, bus_we_r, bus_sys_r;
  logic [AW-1:0]              bus_addr_r;
  logic [DW-1:0]              bus_wdata_r;

  mem_lane_pick #(.LANES(LANES), .IW(IW)) u_pick (
    .pend (pend_r),
    .idx  (pick_idx_s),
    .any  (pick_any_s)
  );

  assign wait_hit_s = (wait_r == WAIT_MAX);

  // Effective opcode per lane at capture; a failed condition clears every lane.
  always_comb begin
    cap_op_s = '0;
    for (int i = 0; i < LANES; i++) begin
      cap_op_s[i] = proceed ? in_op[i*3 +: 3] : OP_CLEAR;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; bus_ack only matters while in BUS.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = (in_valid && in_ready_r) ? ST_SCAN : ST_IDLE;
      ST_SCAN: state_nxt_s = pick_any_s ? ST_BUS : ST_DONE;
      ST_BUS:  state_nxt_s = (bus_ack || wait_hit_s) ? ST_SCAN : ST_BUS;
      ST_DONE: state_nxt_s = out_ready ? ST_IDLE : ST_DONE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath: bundle capture, bus launch, result write-back and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r        <= '0;
      data_r      <= '0;
      addr_r      <= '0;
      res_r       <= '0;
      err_r       <= '0;
      pend_r      <= '0;
      sel_r       <= '0;
      wait_r      <= 8'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_sys_r   <= 1'b0;
      bus_addr_r  <= '0;
      bus_wdata_r <= '0;
    end else begin
      // Handshake outputs track the state being entered so they line up with it.
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
      bus_req_r   <= (state_nxt_s == ST_BUS);
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            for (int i = 0; i < LANES; i++) begin
              op_r[i]   <= cap_op_s[i];
              data_r[i] <= in_data[i*DW +: DW];
              addr_r[i] <= in_addr[i*AW +: AW];
              res_r[i]  <= (cap_op_s[i] == OP_PASS) ? in_data[i*DW +: DW] : '0;
              err_r[i]  <= 1'b0;
              pend_r[i] <= op_is_mem(cap_op_s[i]);
            end
          end else begin
            pend_r <= pend_r;
          end
        end
        ST_SCAN: begin
          wait_r <= 8'd0;
          if (pick_any_s) begin
            sel_r       <= pick_idx_s;
            bus_we_r    <= op_is_store(op_r[pick_idx_s]);
            bus_sys_r   <= op_is_sys(op_r[pick_idx_s]);
            bus_addr_r  <= addr_r[pick_idx_s];
            bus_wdata_r <= data_r[pick_idx_s];
          end else begin
            sel_r <= sel_r;
          end
        end
        ST_BUS: begin
          if (bus_ack) begin
            res_r[sel_r]  <= op_is_store(op_r[sel_r]) ? data_r[sel_r] : bus_rdata;
            pend_r[sel_r] <= 1'b0;
          end else if (wait_hit_s) begin
            res_r[sel_r]  <= '0;
            err_r[sel_r]  <= 1'b1;
            pend_r[sel_r] <= 1'b0;
          end else begin
            wait_r <= wait_r + 8'd1;
          end
        end
        ST_DONE: begin
          res_r <= res_r;
        end
        default: begin
          pend_r <= '0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = res_r;
  assign out_err   = err_r;
  assign bus_req   = bus_req_r;
  assign bus_we    = bus_we_r;
  assign bus_sys   = bus_sys_r;
  assign bus_addr  = bus_addr_r;
  assign bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage (LANES=2, TIMEOUT=4).
// A bundle-level model predicts results, error flags, the order and shape
// of bus transactions and the out_valid latency; a bus responder acks each
// transaction after a chosen number of wait cycles (or never).
module tb_mem_access_stage;

  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int LANES   = 2;
  localparam int TIMEOUT = 4;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [LANES*3-1:0]  in_op;
  logic [LANES*DW-1:0] in_data;
  logic [LANES*AW-1:0] in_addr;
  logic                proceed;
  logic                out_valid;
  logic [LANES*DW-1:0] out_data;
  logic [LANES-1:0]    out_err;
  logic                out_ready;
  logic                bus_req;
  logic                bus_we;
  logic                bus_sys;
  logic [AW-1:0]       bus_addr;
  logic [DW-1:0]       bus_wdata;
  logic                bus_ack;
  logic [DW-1:0]       bus_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // Per-bundle stimulus; t_delay = no-ack cycles before ack (>= TIMEOUT: never acked).
  logic [2:0]    t_op[LANES];
  logic [DW-1:0] t_data[LANES];
  logic [DW-1:0] t_rdata[LANES];
  logic [AW-1:0] t_addr[LANES];
  int            t_delay[LANES];
  logic          t_proceed;
  int            t_hold;

  mem_access_stage #(.DW(DW), .AW(AW), .LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .proceed   (proceed),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_ready (out_ready),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_sys   (bus_sys),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int bus_cycles(input int delay);
    return (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
  endfunction

  task automatic drive_bundle();
    for (int i = 0; i < LANES; i++) begin
      in_op[i*3 +: 3]    = t_op[i];
      in_data[i*DW +: DW] = t_data[i];
      in_addr[i*AW +: AW] = t_addr[i];
    end
    proceed  = t_proceed;
    in_valid = 1'b1;
  endtask

  task automatic scramble_inputs();
    in_valid = 1'b0;
    in_op    = LANES*3'($urandom);
    in_data  = {$urandom, $urandom};
    in_addr  = {$urandom, $urandom};
    proceed  = 1'($urandom);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_bundle();
    int q[$];
    int exp_lat, c, txn, bcnt, lane;
    bit seen;
    logic [2:0] lop;
    logic [LANES*DW-1:0] exp_data;
    logic [LANES-1:0] exp_err;

    exp_lat  = 2;
    exp_data = '0;
    exp_err  = '0;
    for (int i = 0; i < LANES; i++) begin
      lop = t_proceed ? t_op[i] : 3'd0;
      if (lop == 3'd1) begin
        exp_data[i*DW +: DW] = t_data[i];
      end else if (lop >= 3'd2 && lop <= 3'd5) begin
        q.push_back(i);
        exp_lat += bus_cycles(t_delay[i]) + 1;
        if (t_delay[i] < TIMEOUT)
          exp_data[i*DW +: DW] = (lop == 3'd3 || lop == 3'd5) ? t_data[i] : t_rdata[i];
        else
          exp_err[i] = 1'b1;
      end
    end

    check_val("in_ready_idle", 64'(in_ready), 64'd1);
    drive_bundle();
    out_ready = 1'b0;
    bus_ack   = 1'b0;
    c = 0; txn = 0; bcnt = 0; lane = 0; seen = 1'b0;
    while (!seen && c < 300) begin
      @(negedge clk);
      c++;
      scramble_inputs();
      if (bus_req) begin
        if (bcnt == 0) begin
          if (txn < q.size()) lane = q[txn];
          else check_val("extra_bus_req", 64'(txn), 64'(q.size()));
        end
        bcnt++;
        lop = t_op[lane];
        check_val("bus_we", 64'(bus_we), 64'(lop == 3'd3 || lop == 3'd5));
        check_val("bus_sys", 64'(bus_sys), 64'(lop >= 3'd4));
        check_val("bus_addr", 64'(bus_addr), 64'(t_addr[lane]));
        if (lop == 3'd3 || lop == 3'd5)
          check_val("bus_wdata", 64'(bus_wdata), 64'(t_data[lane]));
        bus_ack   = (bcnt == t_delay[lane] + 1);
        bus_rdata = bus_ack ? t_rdata[lane] : $urandom;
      end else begin
        if (bcnt > 0) begin
          check_val("bus_req_len", 64'(bcnt), 64'(bus_cycles(t_delay[lane])));
          txn++;
          bcnt = 0;
        end
        // Stray acks while no request is outstanding must be ignored.
        bus_ack   = 1'($urandom);
        bus_rdata = $urandom;
      end
      seen = out_valid;
    end
    bus_ack = 1'b0;
    check_val("out_valid_seen", 64'(seen), 64'd1);
    check_val("latency", 64'(c), 64'(exp_lat));
    check_val("txn_count", 64'(txn), 64'(q.size()));
    check_val("out_data", 64'(out_data), 64'(exp_data));
    check_val("out_err", 64'(out_err), 64'(exp_err));
    for (int h = 0; h < t_hold; h++) begin
      @(negedge clk);
      bus_ack = 1'($urandom);
      check_val("hold_valid", 64'(out_valid), 64'd1);
      check_val("hold_data", 64'(out_data), 64'(exp_data));
      check_val("hold_err", 64'(out_err), 64'(exp_err));
      check_val("hold_in_ready", 64'(in_ready), 64'd0);
      check_val("hold_no_req", 64'(bus_req), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    bus_ack   = 1'b0;
    check_val("release_valid", 64'(out_valid), 64'd0);
    check_val("release_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic set_lane(input int i, input logic [2:0] op, input logic [DW-1:0] d,
                          input logic [AW-1:0] a, input int dly, input logic [DW-1:0] rd);
    t_op[i] = op; t_data[i] = d; t_addr[i] = a; t_delay[i] = dly; t_rdata[i] = rd;
  endtask

  initial begin
    int c;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_data = '0; in_addr = '0;
    proceed = 1'b0; out_ready = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_bus_req", 64'(bus_req), 64'd0);
    check_val("rst_out_data", 64'(out_data), 64'd0);
    check_val("rst_out_err", 64'(out_err), 64'd0);

    // PASS/CLEAR only: no bus traffic, out_valid two cycles from the capture cycle.
    t_proceed = 1'b1; t_hold = 0;
    set_lane(0, 3'd1, 32'hA5A5_0001, 32'h0, 0, 32'h0);
    set_lane(1, 3'd0, 32'hFFFF_FFFF, 32'h0, 0, 32'h0);
    run_bundle();

    // RAM load then SYS store, each acked on its third bus cycle.
    set_lane(0, 3'd2, 32'h5555_0000, 32'h100, 2, 32'hDEAD_BEEF);
    set_lane(1, 3'd5, 32'h0000_1234, 32'h20, 2, 32'h0BAD_F00D);
    run_bundle();

    // Condition false: memory ops become CLEAR.
    t_proceed = 1'b0;
    set_lane(0, 3'd3, 32'h1111_1111, 32'h40, 0, 32'h0);
    set_lane(1, 3'd2, 32'h2222_2222, 32'h44, 0, 32'h3333_3333);
    run_bundle();

    // Unacked RAM load times out after TIMEOUT bus cycles.
    t_proceed = 1'b1;
    set_lane(0, 3'd2, 32'h0, 32'h80, 1000, 32'h7777_7777);
    set_lane(1, 3'd0, 32'h9999_9999, 32'h0, 0, 32'h0);
    run_bundle();

    // Back-pressure in DONE for 5 cycles.
    t_hold = 5;
    set_lane(0, 3'd1, 32'hCAFE_0001, 32'h0, 0, 32'h0);
    set_lane(1, 3'd4, 32'h0, 32'hC0, 0, 32'h1357_9BDF);
    run_bundle();

    // Reset during the second BUS cycle aborts the transaction.
    t_hold = 0;
    set_lane(0, 3'd2, 32'h0, 32'h200, 1000, 32'h0);
    set_lane(1, 3'd3, 32'h4444, 32'h204, 0, 32'h0);
    drive_bundle();
    c = 0;
    for (int k = 0; k < 20 && c < 2; k++) begin
      @(negedge clk);
      scramble_inputs();
      if (bus_req) c++;
    end
    check_val("rst_test_bus_cycles", 64'(c), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_bus_req", 64'(bus_req), 64'd0);
    check_val("abort_out_valid", 64'(out_valid), 64'd0);
    check_val("abort_in_ready", 64'(in_ready), 64'd1);
    check_val("abort_out_data", 64'(out_data), 64'd0);
    check_val("abort_out_err", 64'(out_err), 64'd0);
    set_lane(0, 3'd3, 32'h6666_0000, 32'h300, 1, 32'h0);
    set_lane(1, 3'd1, 32'h6666_0001, 32'h0, 0, 32'h0);
    run_bundle();

    // Randomised bundles, including timeouts and stray acks.
    for (int n = 0; n < 40; n++) begin
      t_proceed = ($urandom_range(0, 9) != 0);
      t_hold    = $urandom_range(0, 3);
      for (int i = 0; i < LANES; i++)
        set_lane(i, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 5), $urandom);
      run_bundle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning data width per lane.
REQ-002 The block SHALL have parameter AW, default 32, meaning bus address width.
REQ-003 The block SHALL have parameter LANES, default 2, range 1..8, meaning number of operand lanes per bundle.
REQ-004 The block SHALL have parameter TIMEOUT, default 16, range 2..255, meaning the maximum number of bus wait cycles before a transaction is aborted.
REQ-005 The block SHALL have port clk, input, width 1, meaning the clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rst, input, width 1, meaning reset; synchronous, active-high.
REQ-007 The block SHALL have input port in_valid, width 1, meaning a bundle is offered, and output port in_ready, width 1, meaning the stage accepts a bundle.
REQ-008 The block SHALL have input ports in_op (LANES*3), in_data (LANES*DW) and in_addr (LANES*AW), meaning per-lane opcode, operand and address; lane i occupies slice i.
REQ-009 The block SHALL have input port proceed, width 1, meaning the condition result; when low at capture, every lane SHALL be treated as CLEAR.
REQ-010 The block SHALL have output ports out_valid (1), out_data (LANES*DW) and out_err (LANES), and input port out_ready (1), meaning the result handshake.
REQ-011 The block SHALL have outputs bus_req (1), bus_we (1), bus_sys (1, 0=RAM, 1=SYS), bus_addr (AW) and bus_wdata (DW); it SHALL have inputs bus_ack (1) and bus_rdata (DW).

Function
REQ-012 Opcodes SHALL be 0 CLEAR (result 0), 1 PASS (result=data), 2 RAM_LD, 3 RAM_ST, 4 SYS_LD, 5 SYS_ST; 6-7 SHALL behave as CLEAR.
REQ-013 A store result SHALL be the lane's own data; a load result SHALL be the bus_rdata sampled on the ack cycle.
REQ-014 The FSM SHALL have states IDLE, SCAN, BUS and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 In IDLE, in_valid&in_ready SHALL capture the bundle, resolve CLEAR/PASS lanes, set a pending bit per memory lane, and go to SCAN.
REQ-016 SCAN SHALL select the lowest-index pending lane and go to BUS; if none is pending it SHALL go to DONE; SCAN SHALL last exactly 1 cycle.
REQ-017 In BUS, bus_req SHALL be 1 and bus_we/bus_sys/bus_addr/bus_wdata SHALL be driven from registers of the selected lane, held stable until ack or abort.
REQ-018 When bus_ack=1 while bus_req=1, the lane result SHALL be written, the pending bit cleared, bus_req dropped on the next cycle, and the FSM SHALL return to SCAN.
REQ-019 The wait counter SHALL count BUS cycles without ack; when it reaches TIMEOUT-1 without ack, the lane result SHALL be set to 0, out_err[i] SHALL be set, the pending bit cleared, and the FSM SHALL go to SCAN.
REQ-020 bus_ack SHALL be ignored outside BUS.
REQ-021 In DONE, out_valid SHALL be 1 and out_data/out_err SHALL be held stable until out_ready=1; the FSM SHALL then go to IDLE.
REQ-022 A bundle with no memory ops SHALL show out_valid 2 cycles after its capture edge; each memory op SHALL add (1 + wait cycles) + 1 SCAN cycle.
REQ-023 Bus transactions SHALL never overlap; at most one bus_req SHALL be outstanding at any time.

Reset
REQ-024 rst SHALL force state IDLE, clear all pending bits and the wait counter, and set every output to 0 except in_ready=1 on the following cycle.
REQ-025 rst during BUS SHALL abort the transaction by deasserting bus_req on the next edge, and no result SHALL be produced.

Structure
REQ-026 Package mem_access_pkg SHALL hold the opcode constants and the FSM state enum.
REQ-027 The lowest-index pending selection SHALL be a sub-module mem_lane_pick (LANES-wide priority encoder with an any-pending flag).

Verification
REQ-028 LANES=2, proceed=1, ops {PASS,CLEAR}, data {0xA5A5_0001, 0xFFFF_FFFF} -> out_data {0xA5A5_0001, 0}, no bus_req, out_valid 2 cycles after capture.
REQ-029 ops {RAM_LD addr 0x100, SYS_ST addr 0x20 data 0x1234}, ack after 3 cycles each -> lane0 request first (we=0, sys=0), then lane1 (we=1, sys=1, wdata 0x1234); out_data lane0 = bus_rdata 0xDEAD_BEEF.
REQ-030 proceed=0 with ops {RAM_ST, RAM_LD} -> no bus_req, out_data {0, 0}.
REQ-031 TIMEOUT=4, RAM_LD never acked -> bus_req held exactly 4 cycles, out_err=2'b01, lane0 result 0.
REQ-032 out_ready held low 5 cycles in DONE -> out_valid/out_data stable, in_ready=0; release -> in_ready=1 on the next cycle.
REQ-033 rst asserted in the 2nd BUS cycle -> bus_req=0 and out_valid=0 after the edge; a new bundle is accepted normally.
